// File: rtl/fifo_sync_param_if.sv
// Purpose: bundles the write/read/error/status signals of fifo_sync_param.
//   master modport: producer/consumer side (drives i_*, observes o_*).
//   slave  modport: the FIFO itself (observes i_*, drives o_*).
// Signals:
//   i_wren / i_wrdata  write request and data
//   i_rden             read request (pop in FWFT mode)
//   i_clr_err          clears the sticky error flags
//   o_rddata           read data
//   o_full / o_empty / o_alm_full / o_alm_empty / o_count   occupancy status
//   o_overflow / o_underflow                              sticky error flags
interface fifo_sync_param_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic              i_clr_err;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wren, i_wrdata, i_rden, i_clr_err,
        input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_clr_err,
        output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Purpose: parametrised single-clock FIFO with optional first-word-fall-through
//   read mode, fill-level output and sticky overflow/underflow flags.
// Ports:
//   clk   clock, all logic on rising edge
//   rstn  synchronous reset, active-high (1 = reset)
//   fifo  fifo_sync_param_if.slave bundle (write/read requests, data, status)
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_sync_param_if.slave    fifo
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             alm_full_q, alm_full_d;
    logic             alm_empty_q, alm_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        // A full FIFO still takes a write when a read frees a slot on the same edge;
        // an empty FIFO never serves a read, even with a write arriving.
        wr_ok = fifo.i_wren & (~full_q | fifo.i_rden);
        rd_ok = fifo.i_rden & ~empty_q;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        alm_full_d  = (count_d >= CNT_W'(AF_LEVEL));
        alm_empty_d = (count_d <= CNT_W'(AE_LEVEL));

        // Setting wins over clearing in the same cycle.
        if (fifo.i_wren & full_q & ~fifo.i_rden) overflow_d = 1'b1;
        else if (fifo.i_clr_err)                  overflow_d = 1'b0;

        if (fifo.i_rden & empty_q)                underflow_d = 1'b1;
        else if (fifo.i_clr_err)                  underflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rstn && wr_ok) mem_q[wr_ptr_q] <= fifo.i_wrdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shows combinationally; forced to zero while empty so the
            // output is clean after reset.
            assign fifo.o_rddata = empty_q ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] rddata_q, rddata_d;

            always_comb begin
                rddata_d = rddata_q;
                if (rd_ok) rddata_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk) begin
                if (rstn) rddata_q <= '0;
                else      rddata_q <= rddata_d;
            end

            assign fifo.o_rddata = rddata_q;
        end
    endgenerate

    assign fifo.o_full      = full_q;
    assign fifo.o_empty     = empty_q;
    assign fifo.o_alm_full  = alm_full_q;
    assign fifo.o_alm_empty = alm_empty_q;
    assign fifo.o_count     = count_q;
    assign fifo.o_overflow  = overflow_q;
    assign fifo.o_underflow = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: one registered-read instance and one FWFT instance,
// default geometry (128-bit, 16 deep, AF 14, AE 2).
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(128), .DEPTH(16)) bus0 ();
    fifo_sync_param_if #(.DATA_W(128), .DEPTH(16)) bus1 ();

    fifo_sync_param #(.DATA_W(128), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
        dut0 (.clk(clk), .rstn(rst), .fifo(bus0));
    fifo_sync_param #(.DATA_W(128), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
        dut1 (.clk(clk), .rstn(rst), .fifo(bus1));

    typedef struct {
        logic         wren;
        logic         rden;
        logic         clr;
        logic [127:0] wdata;
        int           cnt;
        logic         ovf;
        logic         udf;
        logic [127:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status of the registered-read instance for a given occupancy.
    task automatic chk0(input string tag, input int cnt, input logic ovf, input logic udf);
        chk({tag, " count"},     128'(bus0.o_count), 128'(cnt));
        chk({tag, " full"},      128'(bus0.o_full), 128'(cnt == 16));
        chk({tag, " empty"},     128'(bus0.o_empty), 128'(cnt == 0));
        chk({tag, " alm_full"},  128'(bus0.o_alm_full), 128'(cnt >= 14));
        chk({tag, " alm_empty"}, 128'(bus0.o_alm_empty), 128'(cnt <= 2));
        chk({tag, " overflow"},  128'(bus0.o_overflow), 128'(ovf));
        chk({tag, " underflow"}, 128'(bus0.o_underflow), 128'(udf));
    endtask

    task automatic step0(input logic w, input logic r, input logic c, input logic [127:0] d);
        bus0.i_wren    = w;
        bus0.i_rden    = r;
        bus0.i_clr_err = c;
        bus0.i_wrdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic w, input logic r, input logic [127:0] d);
        bus1.i_wren   = w;
        bus1.i_rden   = r;
        bus1.i_wrdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] q[$];
        logic [127:0] exp_d;
        logic         udf_m;

        bus0.i_wren = 1'b0; bus0.i_rden = 1'b0; bus0.i_clr_err = 1'b0; bus0.i_wrdata = '0;
        bus1.i_wren = 1'b0; bus1.i_rden = 1'b0; bus1.i_clr_err = 1'b0; bus1.i_wrdata = '0;

        //            wren  rden  clr   wdata     cnt ovf   udf   rdata
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 128'h0,   0, 1'b0, 1'b1, 128'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 128'h0,   0, 1'b0, 1'b0, 128'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 128'h11,  1, 1'b0, 1'b1, 128'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 128'h0,   1, 1'b0, 1'b0, 128'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 128'h22,  2, 1'b0, 1'b0, 128'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 128'h33,  3, 1'b0, 1'b0, 128'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 128'h0,   2, 1'b0, 1'b0, 128'h11};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 128'h44,  2, 1'b0, 1'b0, 128'h22};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 128'h0,   1, 1'b0, 1'b0, 128'h33};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 128'h0,   1, 1'b0, 1'b0, 128'h33};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 128'h0,   0, 1'b0, 1'b0, 128'h44};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 128'h0,   0, 1'b0, 1'b1, 128'h44};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 128'h0,   0, 1'b0, 1'b1, 128'h44};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 128'h0,   0, 1'b0, 1'b0, 128'h44};

        // Reset held for two clocks.
        rst = 1'b1;
        step0(1'b0, 1'b0, 1'b0, '0);
        step0(1'b0, 1'b0, 1'b0, '0);
        chk0("reset", 0, 1'b0, 1'b0);
        chk("reset rddata0", bus0.o_rddata, 128'h0);
        chk("reset empty1", 128'(bus1.o_empty), 128'h1);
        chk("reset count1", 128'(bus1.o_count), 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step0(vecs[i].wren, vecs[i].rden, vecs[i].clr, vecs[i].wdata);
            chk0($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
            chk($sformatf("vec%0d rddata", i), bus0.o_rddata, vecs[i].rdata);
        end

        // Fill with 0..15; almost-full appears at 14, full at 16.
        for (int k = 0; k < 16; k++) begin
            step0(1'b1, 1'b0, 1'b0, 128'(k));
            chk0($sformatf("fill%0d", k), k + 1, 1'b0, 1'b0);
        end

        // Rejected write while full: count unchanged, sticky overflow.
        step0(1'b1, 1'b0, 1'b0, 128'hDEAD);
        chk0("overflow", 16, 1'b1, 1'b0);
        step0(1'b0, 1'b0, 1'b1, '0);
        chk0("overflow clr", 16, 1'b0, 1'b0);

        // Full with simultaneous read and write: both taken.
        step0(1'b1, 1'b1, 1'b0, 128'd100);
        chk0("full rw", 16, 1'b0, 1'b0);
        chk("full rw rddata", bus0.o_rddata, 128'd0);

        // Drain: 1..15 then the word written while full; the rejected one never appears.
        for (int k = 0; k < 16; k++) begin
            step0(1'b0, 1'b1, 1'b0, '0);
            chk($sformatf("drain%0d rddata", k), bus0.o_rddata, (k < 15) ? 128'(k + 1) : 128'd100);
            chk0($sformatf("drain%0d", k), 15 - k, 1'b0, 1'b0);
        end

        // 40 mixed operations against a queue reference; pointers wrap.
        udf_m = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic w, r, wok, rok;
            w = (i < 30) && (i % 4 != 3);
            r = (i < 30) ? (i % 2 == 0) : 1'b1;
            wok = w && ((q.size() != 16) || r);
            rok = r && (q.size() != 0);
            if (r && q.size() == 0) udf_m = 1'b1;
            exp_d = '0;
            if (rok) exp_d = q.pop_front();
            if (wok) q.push_back(128'h1000 + 128'(i));
            step0(w, r, 1'b0, 128'h1000 + 128'(i));
            chk($sformatf("mix%0d count", i), 128'(bus0.o_count), 128'(q.size()));
            if (rok) chk($sformatf("mix%0d rddata", i), bus0.o_rddata, exp_d);
        end
        chk0("mix end", 0, 1'b0, udf_m);
        step0(1'b0, 1'b0, 1'b1, '0);
        chk0("mix clr", 0, 1'b0, 1'b0);
        step0(1'b0, 1'b0, 1'b0, '0);

        // FWFT instance: head word visible the cycle after a write into empty.
        step1(1'b1, 1'b0, 128'hA5);
        chk("fwft first", bus1.o_rddata, 128'hA5);
        chk("fwft first empty", 128'(bus1.o_empty), 128'h0);
        step1(1'b0, 1'b0, '0);
        chk("fwft hold", bus1.o_rddata, 128'hA5);
        for (int k = 0; k < 6; k++) step1(1'b1, 1'b0, 128'hB0 + 128'(k));
        chk("fwft count7", 128'(bus1.o_count), 128'd7);
        chk("fwft head", bus1.o_rddata, 128'hA5);
        step1(1'b0, 1'b1, '0);
        chk("fwft pop", bus1.o_rddata, 128'hB0);
        chk("fwft pop count", 128'(bus1.o_count), 128'd6);
        step1(1'b1, 1'b0, 128'hB6);
        chk("fwft count7b", 128'(bus1.o_count), 128'd7);

        // Reset mid-operation discards contents.
        bus1.i_wren = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("fwft rst count", 128'(bus1.o_count), 128'd0);
        chk("fwft rst empty", 128'(bus1.o_empty), 128'h1);
        chk("fwft rst alm_empty", 128'(bus1.o_alm_empty), 128'h1);
        chk("fwft rst full", 128'(bus1.o_full), 128'h0);
        chk("fwft rst rddata", bus1.o_rddata, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
